// File: rtl/serial_tx_pkg.sv
// rtl/serial_tx_pkg.sv - shared state encoding, line idle level and parity helper for serial_tx
package serial_tx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_e;

  localparam logic LINE_IDLE = 1'b1;

  // Words up to 64 bits are zero-extended by the caller; zeros do not change the XOR.
  function automatic logic even_parity(input logic [63:0] word);
    return ^word;
  endfunction

endpackage

// File: rtl/serial_tx_baud_tick.sv
// rtl/serial_tx_baud_tick.sv - CLKS_PER_BIT-modulo counter emitting a one-cycle tick at each bit boundary
module baud_tick #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic clr_n,
  input  logic en,
  output logic tick
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt_q;

  assign tick = en && (cnt_q == LAST_CNT);

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      cnt_q <= '0;
    end else if (!en) begin
      cnt_q <= '0;
    end else if (tick) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/serial_tx.sv
// rtl/serial_tx.sv - LSB-first start/stop framed serial transmitter with line break override
// Define SERIAL_TX_PARITY_EN to insert an even-parity bit between the data bits and the stop bit.
module serial_tx
  import serial_tx_pkg::*;
#(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 16
) (
  input  logic              clk,
  input  logic              clr_n,
  input  logic [DATA_W-1:0] data_in,
  input  logic              valid,
  output logic              ready,
  input  logic              brk,
  output logic              tx,
  output logic              busy
);

  localparam int BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_W - 1);

  state_e            state_q;
  logic [DATA_W-1:0] shift_q;
  logic [BIT_W-1:0]  bit_cnt_q;
  logic              tx_q;
  logic              ready_q;
  logic              busy_q;
  logic              tick;
  logic              accept;
  logic              line_d;
`ifdef SERIAL_TX_PARITY_EN
  logic              parity_q;
`endif

  // brk gates ready combinationally so no word slips in on the cycle brk rises.
  assign ready  = ready_q && !brk;
  assign accept = valid && ready;
  assign tx     = tx_q;
  assign busy   = busy_q;

  baud_tick #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud_tick (
    .clk   (clk),
    .clr_n (clr_n),
    .en    (state_q != IDLE),
    .tick  (tick)
  );

  always_comb begin
    line_d = LINE_IDLE;
    case (state_q)
      START:   line_d = 1'b0;
      DATA:    line_d = shift_q[0];
`ifdef SERIAL_TX_PARITY_EN
      PARITY:  line_d = parity_q;
`endif
      default: line_d = LINE_IDLE;
    endcase
  end

  // tx lags the state by one cycle, so the start bit appears the edge after accept.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      tx_q      <= LINE_IDLE;
      ready_q   <= 1'b1;
      busy_q    <= 1'b0;
`ifdef SERIAL_TX_PARITY_EN
      parity_q  <= 1'b0;
`endif
    end else begin
      tx_q <= brk ? 1'b0 : line_d;
      case (state_q)
        IDLE: begin
          if (accept) begin
            state_q  <= START;
            shift_q  <= data_in;
            ready_q  <= 1'b0;
            busy_q   <= 1'b1;
`ifdef SERIAL_TX_PARITY_EN
            parity_q <= even_parity(64'(data_in));
`endif
          end
        end
        START: begin
          if (tick) state_q <= DATA;
        end
        DATA: begin
          if (tick) begin
            shift_q <= shift_q >> 1;
            if (bit_cnt_q == LAST_BIT) begin
              bit_cnt_q <= '0;
`ifdef SERIAL_TX_PARITY_EN
              state_q   <= PARITY;
`else
              state_q   <= STOP;
`endif
            end else begin
              bit_cnt_q <= bit_cnt_q + 1'b1;
            end
          end
        end
`ifdef SERIAL_TX_PARITY_EN
        PARITY: begin
          if (tick) state_q <= STOP;
        end
`endif
        STOP: begin
          if (tick) begin
            state_q <= IDLE;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
